vliw_forward_unit: RTL and testbench
====================================

Name: vliw_forward_unit

Overview:
- Centralised operand-forwarding and hazard unit for a VLIW integer core with LANES parallel IEU lanes.
- Replaces the per-lane forwarding stubs with one block that owns the Memory and Writeback stage destination pipelines of every lane.
- Selects, for each Execute-stage source operand, the youngest producing lane and stage.
- Keeps a register scoreboard for multi-cycle results (divide, FPU-to-int) and raises a Decode stall on load-use or scoreboard hazards.

Parameters:
LANES, 4, number of parallel IEU lanes (1..8); lane index i also gives program order within a bundle (higher index = younger).
LW, max(1,$clog2(LANES)), lane-index field width (localparam).
NREGS, 32, architectural integer registers; x0 is never forwarded, scoreboarded or stalled on.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
StallM, StallW  in  1 each  hold M / W stage registers
FlushM, FlushW  in  1 each  invalidate M / W stage contents
Rs1D, Rs2D  in  LANES*5  Decode source registers, lane i at [5i+:5]
Rs1E, Rs2E, RdE  in  LANES*5  Execute source and destination registers
RegWriteE  in  LANES  lane writes RdE through the normal pipeline
LoadE  in  LANES  lane's Execute instruction is a load
MCIssueE  in  LANES  lane's Execute instruction is multi-cycle; result returns later via MCDoneW
MCDoneW  in  1  a multi-cycle result is written this cycle
MCRdW  in  5  destination of the completing multi-cycle result
FwdStageAE, FwdStageBE  out  LANES*2  per lane: 00 regfile, 01 from W, 10 from M
FwdLaneAE, FwdLaneBE  out  LANES*LW  producing lane for a non-zero stage select
RegWriteM, RegWriteW  out  LANES  pipelined write enables
RdM, RdW  out  LANES*5  pipelined destinations
LoadStallD  out  1  load-use hazard
ScoreboardStallD  out  1  Decode source is pending a multi-cycle result
StallReqD  out  1  LoadStallD | ScoreboardStallD
WAWErrE  out  1  two lanes in the Execute bundle write the same nonzero Rd
Pending  out  NREGS  scoreboard vector (bit 0 tied 0)

Behaviour:
- Reset (reset==0 at a clk edge) clears RegWriteM, RegWriteW, RdM, RdW and Pending. All stall and error outputs read 0 once reset completes. Reset asserted mid-operation discards all in-flight state, including pending multi-cycle results.
- M register update on each edge:
  - FlushM: RegWriteM <= 0.
  - else if !StallM: RegWriteM[i] <= RegWriteE[i] & ~MCIssueE[i]; RdM <= RdE.
  - StallM: hold.
- W stage is identical, using StallW/FlushW and fed from the M registers. Write-enables to regfile lanes are unchanged; the integrating top drives them from RegWriteW.
- Forwarding is combinational, one cycle of visibility per stage.
  - A match requires RegWrite*[j] and Rd*[j]==RsXE[i] and RsXE[i]!=0.
  - Any M match has priority over any W match.
  - Within a stage, the highest matching lane index wins.
  - With no match, output 00 and lane 0.
- Load-use: LoadStallD=1 if any lane j has LoadE[j], RegWriteE[j] and nonzero RdE[j] equal to any Rs1D/Rs2D of any lane.
- Scoreboard:
  - Pending[r] sets on the edge where the E bundle advances (!StallM && !FlushM) with MCIssueE[j] and RdE[j]==r.
  - Pending[MCRdW] clears when MCDoneW.
  - Set and clear of the same r in one cycle leaves Pending[r]=1.
  - Clear of a non-pending register is ignored.
- ScoreboardStallD=1 if any nonzero Rs1D/Rs2D hits Pending, or hits an RdE with MCIssueE (the not-yet-registered issue).
- WAWErrE is combinational over RegWriteE|MCIssueE lanes. It is a diagnostic only and does not alter state.
- All stall outputs are combinational from current inputs and state; no added latency.

Decomposition:
- Shared package holds the forward-stage encoding constants FWD_RF, FWD_W, FWD_M and the lane-index width function.
- One natural sub-module, fwd_select: the per-operand priority match over 2*LANES candidates, instantiated 2*LANES times.
- The scoreboard stays inline.

Test Plan:
- LANES=4; lane 2 M RdM=5 RegWriteM=1, lane 0 W RdW=5; lane 1 Rs1E=5 -> FwdStageAE[1]=10, FwdLaneAE[1]=2.
- Lanes 1 and 3 both in M writing x7; lane 0 Rs2E=7 -> FwdStageBE[0]=10, FwdLaneBE[0]=3. The same case with Rs2E=0 -> 00.
- Lane 0 LoadE, RdE=9; lane 3 Rs2D=9 -> LoadStallD=1, StallReqD=1. With RdE=0 -> LoadStallD=0.
- Lane 1 MCIssueE RdE=12 advances -> Pending[12]=1 next cycle, and Rs1D=12 stalls. MCDoneW with MCRdW=12 -> Pending[12]=0 and the stall drops next cycle. Same-cycle reissue of x12 with MCDoneW -> Pending[12] stays 1.
- StallM=1 holds RdM across 3 cycles; FlushM clears RegWriteM and forwarding reverts to 00.
- Reset driven low with Pending=0x0000_1200 and RegWriteW=4'b1111 -> all cleared on the next edge. Lanes 0 and 2 with RdE=4 and RegWriteE -> WAWErrE=1.

Source files
------------

// File: rtl/vliw_forward_unit_pkg.sv
// Shared constants and helpers for the VLIW forwarding/hazard unit.
package vliw_forward_unit_pkg;

  // Forward-stage select encoding for each Execute operand.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Width of a register specifier.
  localparam int REG_W = 5;

  // Lane-index field width; a single lane still gets a 1-bit field.
  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vliw_forward_unit_if.sv
// Bundle of pipeline-control, register-specifier and hazard signals
// exchanged between the integrating core and the forwarding unit.
interface vliw_forward_unit_if #(
  parameter int LANES = 4,
  parameter int NREGS = 32
) ();
  import vliw_forward_unit_pkg::*;

  localparam int LW = lane_width(LANES);

  logic                  StallM;
  logic                  StallW;
  logic                  FlushM;
  logic                  FlushW;
  logic [LANES*5-1:0]    Rs1D;
  logic [LANES*5-1:0]    Rs2D;
  logic [LANES*5-1:0]    Rs1E;
  logic [LANES*5-1:0]    Rs2E;
  logic [LANES*5-1:0]    RdE;
  logic [LANES-1:0]      RegWriteE;
  logic [LANES-1:0]      LoadE;
  logic [LANES-1:0]      MCIssueE;
  logic                  MCDoneW;
  logic [4:0]            MCRdW;
  logic [LANES*2-1:0]    FwdStageAE;
  logic [LANES*2-1:0]    FwdStageBE;
  logic [LANES*LW-1:0]   FwdLaneAE;
  logic [LANES*LW-1:0]   FwdLaneBE;
  logic [LANES-1:0]      RegWriteM;
  logic [LANES-1:0]      RegWriteW;
  logic [LANES*5-1:0]    RdM;
  logic [LANES*5-1:0]    RdW;
  logic                  LoadStallD;
  logic                  ScoreboardStallD;
  logic                  StallReqD;
  logic                  WAWErrE;
  logic [NREGS-1:0]      Pending;

  // Core side: drives pipeline state, consumes forwarding and stalls.
  modport master (
    output StallM, StallW, FlushM, FlushW, Rs1D, Rs2D, Rs1E, Rs2E, RdE,
           RegWriteE, LoadE, MCIssueE, MCDoneW, MCRdW,
    input  FwdStageAE, FwdStageBE, FwdLaneAE, FwdLaneBE, RegWriteM, RegWriteW,
           RdM, RdW, LoadStallD, ScoreboardStallD, StallReqD, WAWErrE, Pending
  );

  // Forwarding-unit side.
  modport slave (
    input  StallM, StallW, FlushM, FlushW, Rs1D, Rs2D, Rs1E, Rs2E, RdE,
           RegWriteE, LoadE, MCIssueE, MCDoneW, MCRdW,
    output FwdStageAE, FwdStageBE, FwdLaneAE, FwdLaneBE, RegWriteM, RegWriteW,
           RdM, RdW, LoadStallD, ScoreboardStallD, StallReqD, WAWErrE, Pending
  );

endinterface

// File: rtl/vliw_forward_unit_fwd_select.sv
// Priority match of one Execute source operand against all M and W
// stage destinations: M beats W, and within a stage the youngest lane wins.
module vliw_forward_unit_fwd_select
  import vliw_forward_unit_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LW    = 2
) (
  input  logic [4:0]         rs,
  input  logic [LANES-1:0]   reg_write_m,
  input  logic [LANES*5-1:0] rd_m,
  input  logic [LANES-1:0]   reg_write_w,
  input  logic [LANES*5-1:0] rd_w,
  output logic [1:0]         stage,
  output logic [LW-1:0]      lane
);

  // Ascending scans let later (younger) lanes overwrite; the M scan runs last so it dominates W.
  always_comb begin
    stage = FWD_RF;
    lane  = '0;
    if (rs != 5'd0) begin
      for (int j = 0; j < LANES; j++) begin
        if (reg_write_w[j] && (rd_w[5*j +: 5] == rs)) begin
          stage = FWD_W;
          lane  = LW'(j);
        end
      end
      for (int j = 0; j < LANES; j++) begin
        if (reg_write_m[j] && (rd_m[5*j +: 5] == rs)) begin
          stage = FWD_M;
          lane  = LW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/vliw_forward_unit.sv
// Centralised operand forwarding, M/W destination pipelines, multi-cycle
// result scoreboard and Decode hazard detection for a VLIW integer core.
module vliw_forward_unit
  import vliw_forward_unit_pkg::*;
#(
  parameter int LANES = 4,
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  vliw_forward_unit_if.slave   bus
);

  localparam int LW = lane_width(LANES);

  logic [LANES-1:0]   reg_write_m_reg;
  logic [LANES-1:0]   reg_write_w_reg;
  logic [LANES*5-1:0] rd_m_reg;
  logic [LANES*5-1:0] rd_w_reg;
  logic [NREGS-1:0]   pending_reg;
  logic [NREGS-1:0]   pending_next;
  logic [LANES*2-1:0] fwd_stage_a;
  logic [LANES*2-1:0] fwd_stage_b;
  logic [LANES*LW-1:0] fwd_lane_a;
  logic [LANES*LW-1:0] fwd_lane_b;
  logic               load_stall;
  logic               sb_stall;
  logic               waw_err;

  // Pipeline M and W destination state; multi-cycle issues never write through M.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_write_m_reg <= '0;
      reg_write_w_reg <= '0;
      rd_m_reg        <= '0;
      rd_w_reg        <= '0;
      pending_reg     <= '0;
    end else begin
      if (bus.FlushM) begin
        reg_write_m_reg <= '0;
      end else if (!bus.StallM) begin
        reg_write_m_reg <= bus.RegWriteE & ~bus.MCIssueE;
        rd_m_reg        <= bus.RdE;
      end
      if (bus.FlushW) begin
        reg_write_w_reg <= '0;
      end else if (!bus.StallW) begin
        reg_write_w_reg <= reg_write_m_reg;
        rd_w_reg        <= rd_m_reg;
      end
      pending_reg <= pending_next;
    end
  end

  // Scoreboard update: completions clear first so a same-cycle reissue keeps the bit set.
  always_comb begin
    pending_next = pending_reg;
    if (bus.MCDoneW) begin
      pending_next[bus.MCRdW] = 1'b0;
    end
    if (!bus.StallM && !bus.FlushM) begin
      for (int j = 0; j < LANES; j++) begin
        if (bus.MCIssueE[j]) begin
          pending_next[bus.RdE[5*j +: 5]] = 1'b1;
        end
      end
    end
    pending_next[0] = 1'b0;
  end

  // One selector per Execute source operand.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_fwd
      vliw_forward_unit_fwd_select #(.LANES(LANES), .LW(LW)) u_sel_a (
        .rs          (bus.Rs1E[5*gi +: 5]),
        .reg_write_m (reg_write_m_reg),
        .rd_m        (rd_m_reg),
        .reg_write_w (reg_write_w_reg),
        .rd_w        (rd_w_reg),
        .stage       (fwd_stage_a[2*gi +: 2]),
        .lane        (fwd_lane_a[LW*gi +: LW])
      );
      vliw_forward_unit_fwd_select #(.LANES(LANES), .LW(LW)) u_sel_b (
        .rs          (bus.Rs2E[5*gi +: 5]),
        .reg_write_m (reg_write_m_reg),
        .rd_m        (rd_m_reg),
        .reg_write_w (reg_write_w_reg),
        .rd_w        (rd_w_reg),
        .stage       (fwd_stage_b[2*gi +: 2]),
        .lane        (fwd_lane_b[LW*gi +: LW])
      );
    end
  endgenerate

  // Decode hazards and the Execute WAW diagnostic, all purely combinational.
  always_comb begin
    load_stall = 1'b0;
    sb_stall   = 1'b0;
    waw_err    = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (bus.LoadE[j] && bus.RegWriteE[j] && (bus.RdE[5*j +: 5] != 5'd0)) begin
        for (int i = 0; i < LANES; i++) begin
          if ((bus.RdE[5*j +: 5] == bus.Rs1D[5*i +: 5]) ||
              (bus.RdE[5*j +: 5] == bus.Rs2D[5*i +: 5])) begin
            load_stall = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (bus.Rs1D[5*i +: 5] != 5'd0 && pending_reg[bus.Rs1D[5*i +: 5]]) sb_stall = 1'b1;
      if (bus.Rs2D[5*i +: 5] != 5'd0 && pending_reg[bus.Rs2D[5*i +: 5]]) sb_stall = 1'b1;
      for (int j = 0; j < LANES; j++) begin
        if (bus.MCIssueE[j] && (bus.Rs1D[5*i +: 5] != 5'd0) &&
            (bus.RdE[5*j +: 5] == bus.Rs1D[5*i +: 5])) sb_stall = 1'b1;
        if (bus.MCIssueE[j] && (bus.Rs2D[5*i +: 5] != 5'd0) &&
            (bus.RdE[5*j +: 5] == bus.Rs2D[5*i +: 5])) sb_stall = 1'b1;
      end
    end
    for (int j = 0; j < LANES; j++) begin
      for (int k = j + 1; k < LANES; k++) begin
        if ((bus.RegWriteE[j] || bus.MCIssueE[j]) && (bus.RegWriteE[k] || bus.MCIssueE[k]) &&
            (bus.RdE[5*j +: 5] != 5'd0) && (bus.RdE[5*j +: 5] == bus.RdE[5*k +: 5])) begin
          waw_err = 1'b1;
        end
      end
    end
  end

  assign bus.FwdStageAE       = fwd_stage_a;
  assign bus.FwdStageBE       = fwd_stage_b;
  assign bus.FwdLaneAE        = fwd_lane_a;
  assign bus.FwdLaneBE        = fwd_lane_b;
  assign bus.RegWriteM        = reg_write_m_reg;
  assign bus.RegWriteW        = reg_write_w_reg;
  assign bus.RdM              = rd_m_reg;
  assign bus.RdW              = rd_w_reg;
  assign bus.Pending          = pending_reg;
  assign bus.LoadStallD       = load_stall;
  assign bus.ScoreboardStallD = sb_stall;
  assign bus.StallReqD        = load_stall | sb_stall;
  assign bus.WAWErrE          = waw_err;

endmodule

// File: tb/tb_vliw_forward_unit.sv
// Directed and randomized check of vliw_forward_unit against a
// behavioural pipeline/scoreboard model.
module tb_vliw_forward_unit;
  import vliw_forward_unit_pkg::*;

  localparam int LANES = 4;
  localparam int NREGS = 32;
  localparam int LW    = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Model state: per-lane M/W destinations and the pending-register set.
  bit              mwe [LANES];
  int              mrd [LANES];
  bit              wwe [LANES];
  int              wrd [LANES];
  bit [NREGS-1:0]  pend;

  always #5 clk = ~clk;

  vliw_forward_unit_if #(.LANES(LANES), .NREGS(NREGS)) bus ();

  vliw_forward_unit #(.LANES(LANES), .NREGS(NREGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int field5(input logic [LANES*5-1:0] v, input int i);
    return int'(v[5*i +: 5]);
  endfunction

  task automatic clear_inputs();
    bus.StallM = 0; bus.StallW = 0; bus.FlushM = 0; bus.FlushW = 0;
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
    bus.RegWriteE = '0; bus.LoadE = '0; bus.MCIssueE = '0;
    bus.MCDoneW = 0; bus.MCRdW = '0;
  endtask

  // Youngest producer: scan M from the highest lane down, then W likewise.
  task automatic fwd_ref(input int rs, output int stage, output int lane);
    stage = 0;
    lane  = 0;
    if (rs == 0) return;
    for (int j = LANES - 1; j >= 0; j--)
      if (mwe[j] && mrd[j] == rs) begin stage = 2; lane = j; return; end
    for (int j = LANES - 1; j >= 0; j--)
      if (wwe[j] && wrd[j] == rs) begin stage = 1; lane = j; return; end
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic settle_check();
    int st, ln;
    bit ld_dst [NREGS];
    bit busy   [NREGS];
    int cnt    [NREGS];
    bit e_ld, e_sb, e_waw;
    logic [LANES-1:0]   e_wm, e_ww;
    logic [LANES*5-1:0] e_rdm, e_rdw;
    #1;
    for (int i = 0; i < LANES; i++) begin
      fwd_ref(field5(bus.Rs1E, i), st, ln);
      check_eq($sformatf("fwdA_stage%0d", i), 64'(bus.FwdStageAE[2*i +: 2]), 64'(st));
      check_eq($sformatf("fwdA_lane%0d", i), 64'(bus.FwdLaneAE[LW*i +: LW]), 64'(ln));
      fwd_ref(field5(bus.Rs2E, i), st, ln);
      check_eq($sformatf("fwdB_stage%0d", i), 64'(bus.FwdStageBE[2*i +: 2]), 64'(st));
      check_eq($sformatf("fwdB_lane%0d", i), 64'(bus.FwdLaneBE[LW*i +: LW]), 64'(ln));
    end
    for (int j = 0; j < LANES; j++) begin
      e_wm[j] = mwe[j];
      e_ww[j] = wwe[j];
      e_rdm[5*j +: 5] = 5'(mrd[j]);
      e_rdw[5*j +: 5] = 5'(wrd[j]);
    end
    check_eq("reg_write_m", 64'(bus.RegWriteM), 64'(e_wm));
    check_eq("reg_write_w", 64'(bus.RegWriteW), 64'(e_ww));
    check_eq("rd_m", 64'(bus.RdM), 64'(e_rdm));
    check_eq("rd_w", 64'(bus.RdW), 64'(e_rdw));
    check_eq("pending", 64'(bus.Pending), 64'(pend));
    for (int r = 0; r < NREGS; r++) begin
      ld_dst[r] = 0;
      busy[r]   = pend[r];
      cnt[r]    = 0;
    end
    for (int j = 0; j < LANES; j++) begin
      if (bus.LoadE[j] && bus.RegWriteE[j]) ld_dst[field5(bus.RdE, j)] = 1;
      if (bus.MCIssueE[j]) busy[field5(bus.RdE, j)] = 1;
      if (bus.RegWriteE[j] || bus.MCIssueE[j]) cnt[field5(bus.RdE, j)]++;
    end
    ld_dst[0] = 0;
    busy[0]   = 0;
    e_ld = 0; e_sb = 0; e_waw = 0;
    for (int i = 0; i < LANES; i++) begin
      if (ld_dst[field5(bus.Rs1D, i)] || ld_dst[field5(bus.Rs2D, i)]) e_ld = 1;
      if (busy[field5(bus.Rs1D, i)] || busy[field5(bus.Rs2D, i)]) e_sb = 1;
    end
    for (int r = 1; r < NREGS; r++) if (cnt[r] >= 2) e_waw = 1;
    check_eq("load_stall", 64'(bus.LoadStallD), 64'(e_ld));
    check_eq("sb_stall", 64'(bus.ScoreboardStallD), 64'(e_sb));
    check_eq("stall_req", 64'(bus.StallReqD), 64'(e_ld | e_sb));
    check_eq("waw_err", 64'(bus.WAWErrE), 64'(e_waw));
    $display("cyc %0d reset=%0b stall_req=%0b waw=%0b pending=%08h rdm=%05h rdw=%05h",
             cyc, reset, bus.StallReqD, bus.WAWErrE, bus.Pending, bus.RdM, bus.RdW);
  endtask

  // Apply one clock edge to both the DUT and the model.
  task automatic advance();
    if (reset === 1'b0) begin
      for (int j = 0; j < LANES; j++) begin
        mwe[j] = 0; mrd[j] = 0; wwe[j] = 0; wrd[j] = 0;
      end
      pend = '0;
    end else begin
      if (bus.FlushW) begin
        for (int j = 0; j < LANES; j++) wwe[j] = 0;
      end else if (!bus.StallW) begin
        for (int j = 0; j < LANES; j++) begin wwe[j] = mwe[j]; wrd[j] = mrd[j]; end
      end
      if (bus.FlushM) begin
        for (int j = 0; j < LANES; j++) mwe[j] = 0;
      end else if (!bus.StallM) begin
        for (int j = 0; j < LANES; j++) begin
          mwe[j] = bus.RegWriteE[j] && !bus.MCIssueE[j];
          mrd[j] = field5(bus.RdE, j);
        end
      end
      if (bus.MCDoneW) pend[bus.MCRdW] = 1'b0;
      if (!bus.StallM && !bus.FlushM)
        for (int j = 0; j < LANES; j++)
          if (bus.MCIssueE[j]) pend[field5(bus.RdE, j)] = 1'b1;
      pend[0] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    advance();
    reset = 1'b1;
    settle_check();
    check_eq("rst_pending", 64'(bus.Pending), 64'd0);
    check_eq("rst_rwm", 64'(bus.RegWriteM), 64'd0);
    check_eq("rst_stall", 64'(bus.StallReqD), 64'd0);

    // M lane 2 and W lane 0 both produce x5: M wins.
    clear_inputs(); bus.RegWriteE[0] = 1; bus.RdE[0 +: 5] = 5'd5;
    settle_check(); advance();
    clear_inputs(); bus.RegWriteE[2] = 1; bus.RdE[10 +: 5] = 5'd5;
    settle_check(); advance();
    clear_inputs(); bus.Rs1E[5 +: 5] = 5'd5;
    settle_check();
    check_eq("t1_stage", 64'(bus.FwdStageAE[3:2]), 64'(FWD_M));
    check_eq("t1_lane", 64'(bus.FwdLaneAE[3:2]), 64'd2);

    // Two M producers of x7: youngest lane wins; x0 never forwards.
    clear_inputs(); bus.RegWriteE = 4'b1010; bus.RdE[5 +: 5] = 5'd7; bus.RdE[15 +: 5] = 5'd7;
    settle_check(); advance();
    clear_inputs(); bus.Rs2E[0 +: 5] = 5'd7;
    settle_check();
    check_eq("t2_stage", 64'(bus.FwdStageBE[1:0]), 64'(FWD_M));
    check_eq("t2_lane", 64'(bus.FwdLaneBE[1:0]), 64'd3);
    bus.Rs2E[0 +: 5] = 5'd0;
    settle_check();
    check_eq("t2_x0_stage", 64'(bus.FwdStageBE[1:0]), 64'(FWD_RF));
    check_eq("t2_x0_lane", 64'(bus.FwdLaneBE[1:0]), 64'd0);

    // Load-use on x9, then with a load to x0.
    clear_inputs(); bus.LoadE[0] = 1; bus.RegWriteE[0] = 1; bus.RdE[0 +: 5] = 5'd9;
    bus.Rs2D[15 +: 5] = 5'd9;
    settle_check();
    check_eq("t3_load", 64'(bus.LoadStallD), 64'd1);
    check_eq("t3_req", 64'(bus.StallReqD), 64'd1);
    bus.RdE[0 +: 5] = 5'd0;
    settle_check();
    check_eq("t3_load_x0", 64'(bus.LoadStallD), 64'd0);
    advance();

    // Multi-cycle x12: issue, pend, complete, then same-cycle reissue.
    clear_inputs(); bus.MCIssueE[1] = 1; bus.RegWriteE[1] = 1; bus.RdE[5 +: 5] = 5'd12;
    bus.Rs1D[0 +: 5] = 5'd12;
    settle_check();
    check_eq("t4_issue_stall", 64'(bus.ScoreboardStallD), 64'd1);
    advance();
    clear_inputs(); bus.Rs1D[0 +: 5] = 5'd12;
    settle_check();
    check_eq("t4_pend12", 64'(bus.Pending[12]), 64'd1);
    check_eq("t4_sb", 64'(bus.ScoreboardStallD), 64'd1);
    bus.MCDoneW = 1; bus.MCRdW = 5'd12;
    settle_check();
    check_eq("t4_sb_done_cycle", 64'(bus.ScoreboardStallD), 64'd1);
    advance();
    bus.MCDoneW = 0;
    settle_check();
    check_eq("t4_pend12_clr", 64'(bus.Pending[12]), 64'd0);
    check_eq("t4_sb_clr", 64'(bus.ScoreboardStallD), 64'd0);
    clear_inputs(); bus.MCIssueE[1] = 1; bus.RdE[5 +: 5] = 5'd12;
    settle_check(); advance();
    bus.MCDoneW = 1; bus.MCRdW = 5'd12;
    settle_check(); advance();
    clear_inputs();
    settle_check();
    check_eq("t4_reissue", 64'(bus.Pending[12]), 64'd1);

    // StallM holds RdM; a flush of M and W removes forwarding.
    clear_inputs(); bus.RegWriteE[0] = 1; bus.RdE[0 +: 5] = 5'd3;
    settle_check(); advance();
    bus.StallM = 1; bus.RdE[0 +: 5] = 5'd6;
    for (int k = 0; k < 3; k++) begin
      settle_check();
      check_eq("t5_hold", 64'(bus.RdM[4:0]), 64'd3);
      advance();
    end
    bus.StallM = 0; bus.FlushM = 1; bus.FlushW = 1; bus.Rs1E[5 +: 5] = 5'd3;
    settle_check();
    check_eq("t5_pre_flush", 64'(bus.FwdStageAE[3:2]), 64'(FWD_M));
    advance();
    bus.FlushM = 0; bus.FlushW = 0; bus.RegWriteE = '0;
    settle_check();
    check_eq("t5_flush_rwm", 64'(bus.RegWriteM), 64'd0);
    check_eq("t5_flush_fwd", 64'(bus.FwdStageAE[3:2]), 64'(FWD_RF));

    // Mid-operation reset with Pending=0x1200 and all W lanes writing.
    clear_inputs(); bus.RegWriteE = 4'b1111;
    bus.RdE = {5'd4, 5'd3, 5'd2, 5'd1};
    settle_check(); advance();
    clear_inputs(); bus.MCIssueE = 4'b0011; bus.RdE[0 +: 5] = 5'd9; bus.RdE[5 +: 5] = 5'd12;
    settle_check(); advance();
    clear_inputs();
    settle_check();
    check_eq("t6_pend", 64'(bus.Pending), 64'h1200);
    check_eq("t6_rww", 64'(bus.RegWriteW), 64'hf);
    reset = 1'b0;
    advance();
    reset = 1'b1;
    settle_check();
    check_eq("t6_rst_pend", 64'(bus.Pending), 64'd0);
    check_eq("t6_rst_rww", 64'(bus.RegWriteW), 64'd0);

    // WAW between lanes 0 and 2 on x4.
    clear_inputs(); bus.RegWriteE = 4'b0101; bus.RdE[0 +: 5] = 5'd4; bus.RdE[10 +: 5] = 5'd4;
    settle_check();
    check_eq("t7_waw", 64'(bus.WAWErrE), 64'd1);
    advance();

    // Randomized traffic over a small register range to force frequent matches.
    for (int n = 0; n < 300; n++) begin
      reset      = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      bus.StallM = ($urandom_range(0, 9) == 0);
      bus.StallW = ($urandom_range(0, 9) == 0);
      bus.FlushM = ($urandom_range(0, 14) == 0);
      bus.FlushW = ($urandom_range(0, 14) == 0);
      for (int i = 0; i < LANES; i++) begin
        bus.Rs1D[5*i +: 5] = 5'($urandom_range(0, 7));
        bus.Rs2D[5*i +: 5] = 5'($urandom_range(0, 7));
        bus.Rs1E[5*i +: 5] = 5'($urandom_range(0, 7));
        bus.Rs2E[5*i +: 5] = 5'($urandom_range(0, 7));
        bus.RdE[5*i +: 5]  = 5'($urandom_range(0, 7));
        bus.MCIssueE[i]    = ($urandom_range(0, 5) == 0);
        bus.LoadE[i]       = ($urandom_range(0, 3) == 0);
      end
      bus.RegWriteE = 4'($urandom);
      bus.MCDoneW   = ($urandom_range(0, 2) == 0);
      bus.MCRdW     = 5'($urandom_range(0, 7));
      settle_check();
      advance();
    end
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
